// File: rtl/round_nearest_even_pkg.sv
// Shared fixed-point adder definitions: default significand width and the
// rounding-decision encoding of the {Round,Sticky} bit pair.
package round_nearest_even_pkg;

    localparam int RNE_DEFAULT_W = 25;

    typedef enum logic [1:0] {
        EXACT      = 2'b00,
        BELOW_HALF = 2'b01,
        TIE        = 2'b10,
        ABOVE_HALF = 2'b11
    } rs_code_e;

endpackage

// File: rtl/round_ne_core.sv
// Combinational round-to-nearest-even: turns a truncated magnitude plus its
// Round/Sticky bits into an N+1-bit rounded sum and an inexact flag.
module round_ne_core
    import round_nearest_even_pkg::*;
#(
    parameter int N = RNE_DEFAULT_W
) (
    input  logic [N-1:0] In,
    input  logic         Round,
    input  logic         Sticky,
    output logic [N:0]   Sum,
    output logic         Inexact
);

    rs_code_e rs;
    logic     inc;

    always_comb begin
        rs  = rs_code_e'({Round, Sticky});
        inc = 1'b0;
        unique case (rs)
            EXACT:      inc = 1'b0;
            BELOW_HALF: inc = 1'b0;
            // Exact half: move only if that lands on an even LSB.
            TIE:        inc = In[0];
            ABOVE_HALF: inc = 1'b1;
            default:    inc = 1'b0;
        endcase
    end

    assign Sum     = {1'b0, In} + {{N{1'b0}}, inc};
    assign Inexact = Round | Sticky;

endmodule

// File: rtl/round_nearest_even.sv
// Registered rounding stage: one result per valid operand, one cycle later.
// Results hold across idle cycles; only OutValid drops.
module round_nearest_even
    import round_nearest_even_pkg::*;
#(
    parameter int N = RNE_DEFAULT_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] In,
    input  logic         Round,
    input  logic         Sticky,
    input  logic         InValid,
    output logic [N-1:0] Out,
    output logic         OutValid,
    output logic         Overflow,
    output logic         Inexact
);

    logic [N:0]   sum;
    logic         inexact;

    logic [N-1:0] out_d, out_q;
    logic         ovf_d, ovf_q;
    logic         inx_d, inx_q;
    logic         vld_d, vld_q;

    round_ne_core #(.N(N)) u_core (
        .In      (In),
        .Round   (Round),
        .Sticky  (Sticky),
        .Sum     (sum),
        .Inexact (inexact)
    );

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        inx_d = inx_q;
        vld_d = InValid;
        if (InValid) begin
            // Carry out of the top bit leaves the magnitude wrapped to zero.
            out_d = sum[N-1:0];
            ovf_d = sum[N];
            inx_d = inexact;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            inx_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            inx_q <= inx_d;
            vld_q <= vld_d;
        end
    end

    assign Out      = out_q;
    assign Overflow = ovf_q;
    assign Inexact  = inx_q;
    assign OutValid = vld_q;

endmodule

// File: tb/tb_round_nearest_even.sv
// Scoreboard bench for round_nearest_even: a 25-bit lane for directed vectors
// and an 8-bit lane swept over every operand and rounding code.
module tb_round_nearest_even;

    typedef struct {
        logic [24:0] out;
        logic        ovf;
        logic        inx;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    logic [24:0] in_a = '0;
    logic        rnd_a = 1'b0, stk_a = 1'b0, vin_a = 1'b1;
    logic [24:0] out_a;
    logic        vout_a, ovf_a, inx_a;

    logic [7:0]  in_b = '0;
    logic        rnd_b = 1'b0, stk_b = 1'b0, vin_b = 1'b1;
    logic [7:0]  out_b;
    logic        vout_b, ovf_b, inx_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        hold_a, hold_b;
    logic        exp_vld_a = 1'b0, exp_vld_b = 1'b0;
    logic        started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    round_nearest_even #(.N(25)) dut_a (
        .Clock(Clock), .Reset(Reset), .In(in_a), .Round(rnd_a), .Sticky(stk_a),
        .InValid(vin_a), .Out(out_a), .OutValid(vout_a), .Overflow(ovf_a), .Inexact(inx_a)
    );

    round_nearest_even #(.N(8)) dut_b (
        .Clock(Clock), .Reset(Reset), .In(in_b), .Round(rnd_b), .Sticky(stk_b),
        .InValid(vin_b), .Out(out_b), .OutValid(vout_b), .Overflow(ovf_b), .Inexact(inx_b)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: scale to quarters, round the integer quotient with ties to even.
    function automatic logic [8:0] ref8(input int v, input int r, input int s);
        int x, q, rem;
        x   = v * 4 + r * 2 + s;
        q   = x >> 2;
        rem = x & 3;
        if (rem > 2 || (rem == 2 && (q & 1) == 1)) q = q + 1;
        return q[8:0];
    endfunction

    task automatic step();
        logic va, vb, rs;
        va = vin_a && !Reset;
        vb = vin_b && !Reset;
        rs = Reset;
        @(posedge Clock);
        #1;
        exp_vld_a = va;
        exp_vld_b = vb;
        if (rs) begin
            hold_a = '{out: '0, ovf: 1'b0, inx: 1'b0};
            hold_b = '{out: '0, ovf: 1'b0, inx: 1'b0};
        end
    endtask

    task automatic set_a(input logic [24:0] v, input logic r, input logic s, input logic vld,
                         input logic [24:0] eo, input logic eovf, input logic einx);
        exp_t e;
        in_a = v; rnd_a = r; stk_a = s; vin_a = vld;
        if (vld && !Reset) begin
            e = '{out: eo, ovf: eovf, inx: einx};
            q_a.push_back(e);
        end
        step();
    endtask

    task automatic set_b(input int v, input int r, input int s, input logic vld);
        exp_t e;
        logic [8:0] res;
        logic [31:0] vv;
        vv = v;
        in_b = vv[7:0]; rnd_b = (r != 0); stk_b = (s != 0); vin_b = vld;
        if (vld && !Reset) begin
            res = ref8(v, r, s);
            e = '{out: {17'b0, res[7:0]}, ovf: res[8], inx: (r != 0) || (s != 0)};
            q_b.push_back(e);
        end
        step();
    endtask

    // Monitor: pops the next expected result whenever a result is due, and
    // otherwise requires the outputs to hold their last value.
    always @(negedge Clock) begin
        if (started) begin
            cmp("a_outvalid", {31'b0, vout_a}, {31'b0, exp_vld_a});
            if (exp_vld_a) begin
                if (q_a.size() == 0) cmp("a_queue_underflow", 32'd1, 32'd0);
                else hold_a = q_a.pop_front();
            end
            cmp("a_out", {7'b0, out_a}, {7'b0, hold_a.out});
            cmp("a_overflow", {31'b0, ovf_a}, {31'b0, hold_a.ovf});
            cmp("a_inexact", {31'b0, inx_a}, {31'b0, hold_a.inx});

            cmp("b_outvalid", {31'b0, vout_b}, {31'b0, exp_vld_b});
            if (exp_vld_b) begin
                if (q_b.size() == 0) cmp("b_queue_underflow", 32'd1, 32'd0);
                else hold_b = q_b.pop_front();
            end
            cmp("b_out", {24'b0, out_b}, {24'b0, hold_b.out[7:0]});
            cmp("b_overflow", {31'b0, ovf_b}, {31'b0, hold_b.ovf});
            cmp("b_inexact", {31'b0, inx_b}, {31'b0, hold_b.inx});
        end
    end

    initial begin
        hold_a = '{out: '0, ovf: 1'b0, inx: 1'b0};
        hold_b = '{out: '0, ovf: 1'b0, inx: 1'b0};

        // Reset for two cycles with valid operands presented; they are dropped.
        in_a = 25'h1FFFFFF; rnd_a = 1'b1; stk_a = 1'b1;
        in_b = 8'hFF; rnd_b = 1'b1; stk_b = 1'b1;
        step();
        started = 1'b1;
        step();
        Reset = 1'b0;
        vin_b = 1'b0;

        // Directed vectors on the 25-bit lane, back to back.
        set_a(25'h0000004, 1'b1, 1'b0, 1'b1, 25'h0000004, 1'b0, 1'b1);
        set_a(25'h0000005, 1'b1, 1'b0, 1'b1, 25'h0000006, 1'b0, 1'b1);
        set_a(25'h0000004, 1'b1, 1'b1, 1'b1, 25'h0000005, 1'b0, 1'b1);
        set_a(25'h0000004, 1'b0, 1'b1, 1'b1, 25'h0000004, 1'b0, 1'b1);
        set_a(25'h00ABCDE, 1'b0, 1'b0, 1'b1, 25'h00ABCDE, 1'b0, 1'b0);
        set_a(25'h0000007, 1'b1, 1'b0, 1'b1, 25'h0000008, 1'b0, 1'b1);
        set_a(25'h1FFFFFE, 1'b1, 1'b0, 1'b1, 25'h1FFFFFE, 1'b0, 1'b1);
        set_a(25'h1FFFFFF, 1'b1, 1'b1, 1'b1, 25'h0000000, 1'b1, 1'b1);
        set_a(25'h1FFFFFF, 1'b1, 1'b0, 1'b1, 25'h0000000, 1'b1, 1'b1);
        set_a(25'h1FFFFFF, 1'b0, 1'b1, 1'b1, 25'h1FFFFFF, 1'b0, 1'b1);
        set_a(25'h1FFFFFF, 1'b0, 1'b0, 1'b1, 25'h1FFFFFF, 1'b0, 1'b0);

        // Valid gating 1,0,0,1: the result holds across the gap.
        set_a(25'h0000013, 1'b1, 1'b1, 1'b1, 25'h0000014, 1'b0, 1'b1);
        set_a(25'h0000777, 1'b1, 1'b1, 1'b0, 25'h0000000, 1'b0, 1'b0);
        set_a(25'h0000777, 1'b0, 1'b0, 1'b0, 25'h0000000, 1'b0, 1'b0);
        set_a(25'h0000020, 1'b0, 1'b0, 1'b1, 25'h0000020, 1'b0, 1'b0);
        set_a(25'h0000000, 1'b0, 1'b0, 1'b0, 25'h0000000, 1'b0, 1'b0);

        // Mid-stream reset discards the operand on the reset edge.
        set_a(25'h0000101, 1'b1, 1'b0, 1'b1, 25'h0000102, 1'b0, 1'b1);
        Reset = 1'b1;
        set_a(25'h0000033, 1'b1, 1'b1, 1'b1, 25'h0000034, 1'b0, 1'b1);
        Reset = 1'b0;
        set_a(25'h0000033, 1'b0, 1'b0, 1'b0, 25'h0000000, 1'b0, 1'b0);
        set_a(25'h0000009, 1'b1, 1'b0, 1'b1, 25'h000000A, 1'b0, 1'b1);
        set_a(25'h0000000, 1'b0, 1'b0, 1'b0, 25'h0000000, 1'b0, 1'b0);

        // Exhaustive 8-bit sweep, back to back.
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < 4; c++) begin
                set_b(i, (c >> 1) & 1, c & 1, 1'b1);
            end
        end
        set_b(0, 0, 0, 1'b0);
        step();
        step();

        cmp("a_results_left", q_a.size(), 32'd0);
        cmp("b_results_left", q_b.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
